// File: rtl/gpu_scale2x_feeder_if.sv
// gpu_scale2x_feeder_if: writer, request and neighbourhood signals of the Scale2X feeder
// master: source renderer / line requester side; slave: the feeder.
// sof, ipix_*: 1x source pixel stream; oline_req/oline_num/oline_busy: 2x line request;
// opix_*: neighbourhood beat towards the Scale2X stage; err: sticky underrun/overrun flags.
interface gpu_scale2x_feeder_if #(parameter int Y_W = 8);
  logic sof;
  logic [8:0] ipix_data;
  logic ipix_en;
  logic ipix_eol;
  logic oline_req;
  logic [Y_W:0] oline_num;
  logic oline_busy;
  logic [8:0] opix_B, opix_D, opix_E, opix_F, opix_H;
  logic [1:0] opix_sel;
  logic opix_en;
  logic [1:0] err;
  modport master (
    output sof, ipix_data, ipix_en, ipix_eol, oline_req, oline_num,
    input oline_busy, opix_B, opix_D, opix_E, opix_F, opix_H, opix_sel, opix_en, err
  );
  modport slave (
    input sof, ipix_data, ipix_en, ipix_eol, oline_req, oline_num,
    output oline_busy, opix_B, opix_D, opix_E, opix_F, opix_H, opix_sel, opix_en, err
  );
endinterface

// File: rtl/gpu_scale2x_feeder.sv
// gpu_scale2x_feeder: 4-bank line ring replaying a 1x source line as a 2x Scale2X neighbourhood burst
// clk: video clock; rst_n: asynchronous active-low reset; s: feeder interface (slave).
module gpu_scale2x_feeder #(
  parameter int LINE_W = 256,
  parameter int X_W = 8,
  parameter int FRAME_H = 224,
  parameter int Y_W = 8
) (
  input logic clk,
  input logic rst_n,
  gpu_scale2x_feeder_if.slave s
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  localparam logic [X_W:0] XMAX = (X_W+1)'(LINE_W);
  localparam logic [X_W:0] KLAST = (X_W+1)'(2*LINE_W-1);
  localparam logic [X_W:0] KRD = (X_W+1)'(2*LINE_W-2);
  localparam logic [Y_W-1:0] HMAX = Y_W'(FRAME_H);
  localparam logic [Y_W-1:0] YLAST = Y_W'(FRAME_H-1);
  localparam logic [Y_W:0] NUM_LIM = (Y_W+1)'(2*FRAME_H);
  state_t state, state_nx;
  logic [X_W:0] wr_x, k, nx;
  logic [Y_W-1:0] wr_line, y, ny, yb, yh;
  logic [Y_W:0] y2, lim;
  logic [8:0] mem [4][LINE_W];
  logic [8:0] rd [4];
  logic [8:0] w1, w2, bn, hn, r_e, r_b, r_h;
  logic [X_W-1:0] rd_a;
  logic odd, p, acc, we, under, ovr, f0, rd_en, rv, ld;
  assign ny = s.oline_num[Y_W:1];
  assign acc = state == IDLE && s.oline_req && s.oline_num < NUM_LIM;
  assign we = !s.sof && s.ipix_en && wr_x < XMAX && wr_line < HMAX;
  assign y2 = {1'b0, ny} + (Y_W+1)'(2);
  assign lim = y2 > {1'b0, HMAX} ? {1'b0, HMAX} : y2;
  assign under = {1'b0, wr_line} < lim;
  // writer is about to overwrite the bank still supplying B of the line in flight
  assign ovr = state != IDLE && y != '0 && we && {1'b0, wr_line} == {1'b0, y} + (Y_W+1)'(3);
  assign yb = y == '0 ? y : y - Y_W'(1);
  assign yh = y == YLAST ? y : y + Y_W'(1);
  assign r_e = rd[y[1:0]];
  assign r_b = rd[yb[1:0]];
  assign r_h = rd[yh[1:0]];
  assign nx = {1'b0, k[X_W:1]} + (X_W+1)'(2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_x <= '0;
      wr_line <= '0;
    end else if (s.sof) begin
      wr_x <= '0;
      wr_line <= '0;
    end else if (s.ipix_eol) begin
      wr_x <= '0;
      wr_line <= wr_line < HMAX ? wr_line + Y_W'(1) : wr_line;
    end else if (s.ipix_en && wr_x < XMAX) begin
      wr_x <= wr_x + (X_W+1)'(1);
    end
  // all four banks are read together; the bank choice is muxed after the read
  // so the first read can be issued in the accept cycle, before y is latched
  always_ff @(posedge clk) begin
    if (we) mem[wr_line[1:0]][wr_x[X_W-1:0]] <= s.ipix_data;
    if (rd_en) for (int b = 0; b < 4; b++) rd[b] <= mem[b][rd_a];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s.err <= '0;
    else if (s.sof) s.err <= '0;
    else s.err <= s.err | {ovr, acc && under};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (acc ? PRIME : IDLE) :
               state == PRIME ? (p ? RUN : PRIME) :
               (k == KLAST ? IDLE : RUN);
  // reads run one source pixel ahead of the displayed pixel so F is at hand;
  // the right-edge read clamps to LINE_W-1, giving F=E there
  always_comb begin
    f0 = state == PRIME && !p;
    rd_en = acc || f0 || (state == RUN && !k[0] && k < KRD);
    rd_a = acc ? '0 : f0 ? X_W'(1) : nx[X_W] ? '1 : nx[X_W-1:0];
    ld = rv && state_nx == RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p <= 1'b0;
      k <= '0;
      y <= '0;
      odd <= 1'b0;
      rv <= 1'b0;
    end else begin
      p <= state == PRIME ? !p : 1'b0;
      k <= state == RUN ? k + (X_W+1)'(1) : '0;
      rv <= rd_en;
      if (acc) begin
        y <= ny;
        odd <= s.oline_num[0];
      end
    end
  // w1/w2 hold source pixels x-1 and x of line y; the first pixel fills both so D=E at x=0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w1 <= '0;
      w2 <= '0;
      bn <= '0;
      hn <= '0;
    end else if (rv) begin
      w1 <= f0 ? r_e : w2;
      w2 <= r_e;
      bn <= r_b;
      hn <= r_h;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s.opix_en <= 1'b0;
      s.oline_busy <= 1'b0;
      s.opix_sel <= '0;
      s.opix_B <= '0;
      s.opix_D <= '0;
      s.opix_E <= '0;
      s.opix_F <= '0;
      s.opix_H <= '0;
    end else begin
      s.opix_en <= state_nx == RUN;
      s.oline_busy <= state_nx != IDLE;
      if (state_nx == RUN) s.opix_sel <= {odd, !ld};
      if (ld) begin
        s.opix_B <= bn;
        s.opix_D <= w1;
        s.opix_E <= w2;
        s.opix_F <= r_e;
        s.opix_H <= hn;
      end
    end
endmodule

// File: tb/tb_gpu_scale2x_feeder.sv
// tb_gpu_scale2x_feeder: scoreboard bench for the Scale2X feeder (LINE_W=4, FRAME_H=3 and 8)
module tb_gpu_scale2x_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gpu_scale2x_feeder_if #(.Y_W(2)) ia();
  gpu_scale2x_feeder_if #(.Y_W(4)) ib();
  gpu_scale2x_feeder #(.LINE_W(4), .X_W(2), .FRAME_H(3), .Y_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .s(ia.slave));
  gpu_scale2x_feeder #(.LINE_W(4), .X_W(2), .FRAME_H(8), .Y_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .s(ib.slave));
  int n_run = 0;
  int n_fail = 0;
  int beats = 0;
  bit ign = 1'b0;
  logic [46:0] q[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [8:0] pix(input int n, input int x);
    return 9'(10 * n + x);
  endfunction
  function automatic logic [46:0] expv(input int num, input int k);
    int y, x;
    y = num / 2;
    x = k / 2;
    return {2'((num % 2) * 2 + k % 2), pix(y > 0 ? y - 1 : 0, x), pix(y, x > 0 ? x - 1 : 0),
            pix(y, x), pix(y, x < 3 ? x + 1 : 3), pix(y < 2 ? y + 1 : 2, x)};
  endfunction
  always @(negedge clk)
    if (ia.opix_en) begin
      if (ign) beats++;
      else if (q.size() == 0) chk("extra_beat", {63'd0, ia.opix_en}, 64'd0);
      else chk("beat", {ia.opix_sel, ia.opix_B, ia.opix_D, ia.opix_E, ia.opix_F, ia.opix_H}, q.pop_front());
    end
  task automatic wline(input int n);
    for (int x = 0; x < 4; x++) begin
      @(posedge clk) #1;
      ia.ipix_en = 1'b1;
      ia.ipix_data = pix(n, x);
      ia.ipix_eol = x == 3;
    end
    @(posedge clk) #1;
    ia.ipix_en = 1'b0;
    ia.ipix_eol = 1'b0;
  endtask
  task automatic wline_b(input int n);
    for (int x = 0; x < 4; x++) begin
      @(posedge clk) #1;
      ib.ipix_en = 1'b1;
      ib.ipix_data = pix(n, x);
      ib.ipix_eol = x == 3;
    end
    @(posedge clk) #1;
    ib.ipix_en = 1'b0;
    ib.ipix_eol = 1'b0;
  endtask
  task automatic req(input int num, input bit push);
    @(posedge clk) #1;
    ia.oline_req = 1'b1;
    ia.oline_num = 3'(num);
    if (push) for (int k = 0; k < 8; k++) q.push_back(expv(num, k));
    @(posedge clk) #1;
    ia.oline_req = 1'b0;
  endtask
  task automatic burst_wait();
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("busy", {63'd0, ia.oline_busy}, {63'd0, c <= 10});
      chk("en", {63'd0, ia.opix_en}, {63'd0, c >= 3 && c <= 10});
    end
  endtask
  task automatic sof_pulse();
    @(posedge clk) #1;
    ia.sof = 1'b1;
    @(posedge clk) #1;
    ia.sof = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    bit found;
    {ia.sof, ia.ipix_en, ia.ipix_eol, ia.oline_req} = '0;
    ia.ipix_data = '0;
    ia.oline_num = '0;
    {ib.sof, ib.ipix_en, ib.ipix_eol, ib.oline_req} = '0;
    ib.ipix_data = '0;
    ib.oline_num = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", {ia.oline_busy, ia.opix_en, ia.opix_sel, ia.err, ia.opix_B, ia.opix_D, ia.opix_E, ia.opix_F, ia.opix_H}, 64'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    wline(0);
    wline(1);
    req(0, 1'b1);
    burst_wait();
    chk("q_left1", q.size(), 0);
    chk("err1", ia.err, 0);
    wline(2);
    req(5, 1'b1);
    burst_wait();
    chk("q_left2", q.size(), 0);
    chk("err2", ia.err, 0);
    req(6, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("range_busy", {63'd0, ia.oline_busy}, 64'd0);
    end
    req(0, 1'b1);
    req(1, 1'b0);
    repeat (12) @(negedge clk);
    chk("q_left4", q.size(), 0);
    chk("busy_end4", {63'd0, ia.oline_busy}, 64'd0);
    sof_pulse();
    wline(0);
    ign = 1'b1;
    beats = 0;
    req(2, 1'b0);
    @(negedge clk);
    chk("underrun", ia.err, 64'd1);
    repeat (12) @(negedge clk);
    chk("ur_beats", beats, 8);
    ign = 1'b0;
    sof_pulse();
    @(negedge clk);
    chk("sof_clr", ia.err, 64'd0);
    wline(0);
    wline(1);
    wline(2);
    req(0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = ia.opix_en;
    end
    chk("en_seen", {63'd0, found}, 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk) #1;
    rst_n = 1'b0;
    #1;
    chk("rst_en", {63'd0, ia.opix_en}, 64'd0);
    chk("rst_busy", {63'd0, ia.oline_busy}, 64'd0);
    chk("rst_left", q.size(), 5);
    q.delete();
    @(posedge clk) #1;
    rst_n = 1'b1;
    wline(0);
    wline(1);
    wline(2);
    req(3, 1'b1);
    burst_wait();
    chk("q_left6", q.size(), 0);
    chk("err6", ia.err, 0);
    for (int n = 0; n < 4; n++) wline_b(n);
    @(posedge clk) #1;
    ib.oline_req = 1'b1;
    ib.oline_num = 5'd2;
    @(posedge clk) #1;
    ib.oline_req = 1'b0;
    chk("ovr_pre", ib.err, 0);
    wline_b(4);
    @(negedge clk);
    chk("overrun", ib.err, 64'd2);
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
